// File: rtl/pattern_seq_if.sv
// Pattern-selection handshake between a controller and the pattern sequencer.
// The requester raises sel_req with a stable sel_pattern and drops it after the one-cycle sel_ack.
interface pattern_seq_if;
    logic       sel_req;
    logic [2:0] sel_pattern;
    logic       sel_ack;

    modport master (output sel_req, output sel_pattern, input sel_ack);
    modport slave  (input sel_req, input sel_pattern, output sel_ack);
endinterface

// File: rtl/pattern_seq.sv
// Test-pattern sequencer: measures active geometry from vs/de, publishes a locked width/height,
// and selects the pattern code, changing it only at frame ticks (manual request or auto-cycle).
module pattern_seq #(
    parameter int unsigned X_BITS      = 13,
    parameter int unsigned Y_BITS      = 13,
    parameter int unsigned HOLD_FRAMES = 300,
    parameter logic [7:0]  AUTO_MASK   = 8'hFD,
    parameter logic [2:0]  DEF_PATTERN = 3'd0
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    input  logic              auto_en,
    pattern_seq_if.slave      sel,
    output logic [2:0]        pattern,
    output logic [X_BITS-1:0] width,
    output logic [Y_BITS-1:0] height,
    output logic              geom_valid
);

    localparam int unsigned FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [FW-1:0] FcntLast = FW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StAcq, StLock} geom_state_e;

    logic              vs_q, de_q, auto_q;
    logic [X_BITS-1:0] wcnt_q, wcnt_d, line_w_q, line_w_d, w_eff;
    logic [Y_BITS-1:0] lines_q, lines_d;
    logic              bad_q, bad_d;
    logic              ft, line_end, good, same;

    geom_state_e       state_q, state_d;
    logic [X_BITS-1:0] cand_w_q, cand_w_d, width_q, width_d;
    logic [Y_BITS-1:0] cand_h_q, cand_h_d, height_q, height_d;
    logic              valid_q, valid_d;

    logic [2:0]        pattern_q, pattern_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              ack_q, ack_d;

    // hs is reserved; measurement relies on de alone.
    logic unused_hs;
    assign unused_hs = hs_in;

    // Next enabled pattern above cur in AUTO_MASK, wrapping; cur itself if none other enabled.
    function automatic logic [2:0] next_pattern(input logic [2:0] cur);
        logic [2:0] idx;
        next_pattern = cur;
        for (int i = 7; i >= 1; i--) begin
            idx = cur + 3'(i);
            if (AUTO_MASK[idx]) next_pattern = idx;
        end
    endfunction

    assign ft       = vs_in & ~vs_q;
    // A frame tick landing inside active video closes that line too.
    assign line_end = (de_q & ~de_in) | (ft & de_in);
    assign w_eff    = (de_in && wcnt_q != '1) ? wcnt_q + 1'b1 : wcnt_q;

    // Per-line DE counting and per-frame line/width consistency tracking.
    always_comb begin
        wcnt_d   = wcnt_q;
        line_w_d = line_w_q;
        lines_d  = lines_q;
        bad_d    = bad_q;
        if (line_end) begin
            wcnt_d = '0;
        end else if (de_in && wcnt_q != '1) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        if (line_end && w_eff != '0) begin
            if (lines_q == '0) begin
                line_w_d = w_eff;
            end else if (w_eff != line_w_q) begin
                bad_d = 1'b1;
            end
            if (lines_q != '1) lines_d = lines_q + 1'b1;
        end
    end

    assign good = !bad_d && (lines_d != '0) && (line_w_d != '0);
    assign same = (line_w_d == cand_w_q) && (lines_d == cand_h_q);

    // Geometry lock FSM, stepped only at frame ticks.
    always_comb begin
        state_d  = state_q;
        cand_w_d = cand_w_q;
        cand_h_d = cand_h_q;
        width_d  = width_q;
        height_d = height_q;
        valid_d  = valid_q;
        if (ft) begin
            unique case (state_q)
                StIdle: begin
                    if (good) begin
                        state_d  = StAcq;
                        cand_w_d = line_w_d;
                        cand_h_d = lines_d;
                    end
                end
                StAcq: begin
                    if (!good) begin
                        state_d = StIdle;
                    end else if (same) begin
                        state_d  = StLock;
                        width_d  = cand_w_q;
                        height_d = cand_h_q;
                        valid_d  = 1'b1;
                    end else begin
                        cand_w_d = line_w_d;
                        cand_h_d = lines_d;
                    end
                end
                StLock: begin
                    if (!(good && same)) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Pattern selection: manual request beats auto advance; both only at a frame tick.
    always_comb begin
        pattern_d = pattern_q;
        fcnt_d    = fcnt_q;
        ack_d     = 1'b0;
        if (auto_q && !auto_en) fcnt_d = '0;
        if (ft && sel.sel_req && !ack_q) begin
            pattern_d = sel.sel_pattern;
            ack_d     = 1'b1;
            fcnt_d    = '0;
        end else if (ft && auto_en && valid_q) begin
            if (fcnt_q == FcntLast) begin
                pattern_d = next_pattern(pattern_q);
                fcnt_d    = '0;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // State registers; measurement accumulators restart at each frame tick.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            auto_q    <= 1'b0;
            wcnt_q    <= '0;
            line_w_q  <= '0;
            lines_q   <= '0;
            bad_q     <= 1'b0;
            state_q   <= StIdle;
            cand_w_q  <= '0;
            cand_h_q  <= '0;
            width_q   <= '0;
            height_q  <= '0;
            valid_q   <= 1'b0;
            pattern_q <= DEF_PATTERN;
            fcnt_q    <= '0;
            ack_q     <= 1'b0;
        end else begin
            vs_q      <= vs_in;
            de_q      <= de_in;
            auto_q    <= auto_en;
            wcnt_q    <= wcnt_d;
            line_w_q  <= ft ? '0 : line_w_d;
            lines_q   <= ft ? '0 : lines_d;
            bad_q     <= ft ? 1'b0 : bad_d;
            state_q   <= state_d;
            cand_w_q  <= cand_w_d;
            cand_h_q  <= cand_h_d;
            width_q   <= width_d;
            height_q  <= height_d;
            valid_q   <= valid_d;
            pattern_q <= pattern_d;
            fcnt_q    <= fcnt_d;
            ack_q     <= ack_d;
        end
    end

    assign pattern     = pattern_q;
    assign width       = width_q;
    assign height      = height_q;
    assign geom_valid  = valid_q;
    assign sel.sel_ack = ack_q;

endmodule

// File: tb/tb_pattern_seq.sv
// Bench for pattern_seq: directed frame table, randomized frames against a frame-level model,
// and a mid-frame asynchronous reset sequence.
module tb_pattern_seq;

    localparam int unsigned HOLD = 3;
    localparam logic [7:0]  MASK = 8'hFD;

    logic        clk_in = 1'b0;
    logic        reset_n, vs_in, hs_in, de_in, auto_en;
    logic [2:0]  pattern;
    logic [12:0] width, height;
    logic        geom_valid;

    pattern_seq_if sel_if ();

    pattern_seq #(
        .X_BITS      (13),
        .Y_BITS      (13),
        .HOLD_FRAMES (HOLD),
        .AUTO_MASK   (MASK),
        .DEF_PATTERN (3'd0)
    ) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .vs_in      (vs_in),
        .hs_in      (hs_in),
        .de_in      (de_in),
        .auto_en    (auto_en),
        .sel        (sel_if),
        .pattern    (pattern),
        .width      (width),
        .height     (height),
        .geom_valid (geom_valid)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int         nl;
        int         w;
        int         bad_line;
        int         bad_w;
        bit         auto_on;
        bit         req;
        logic [2:0] rpat;
        logic [2:0] e_pat;
        int         e_w;
        int         e_h;
        bit         e_v;
    } vec_t;

    vec_t vecs[$];

    // Frame-level reference model.
    int m_pat, m_fcnt, m_w, m_h, m_cw, m_ch;
    bit m_valid, m_cand_ok;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input int nl, input int w, input int bl, input int bw,
                                input bit au, input bit rq, input logic [2:0] rp,
                                input logic [2:0] ep, input int ew, input int eh, input bit ev);
        vec_t v;
        v.nl = nl; v.w = w; v.bad_line = bl; v.bad_w = bw;
        v.auto_on = au; v.req = rq; v.rpat = rp;
        v.e_pat = ep; v.e_w = ew; v.e_h = eh; v.e_v = ev;
        vecs.push_back(v);
    endfunction

    function automatic int next_enabled(input int p);
        for (int k = 1; k < 8; k++) begin
            if (MASK[(p + k) % 8]) return (p + k) % 8;
        end
        return p;
    endfunction

    function automatic void model_reset();
        m_pat = 0; m_fcnt = 0; m_w = 0; m_h = 0; m_cw = 0; m_ch = 0;
        m_valid = 1'b0; m_cand_ok = 1'b0;
    endfunction

    // One frame tick: pattern rules use the lock status from before this frame.
    function automatic void model_ft(input int nl, input int w, input int bl, input int bw,
                                     input bit rq, input logic [2:0] rp);
        bit good;
        bit eq;
        good = (nl > 0) && (w > 0) && (bl < 0 || bl >= nl || bw == w);
        eq   = (w == m_cw) && (nl == m_ch);
        if (rq) begin
            m_pat = int'(rp); m_fcnt = 0;
        end else if (auto_en && m_valid) begin
            if (m_fcnt == int'(HOLD) - 1) begin
                m_pat = next_enabled(m_pat); m_fcnt = 0;
            end else begin
                m_fcnt++;
            end
        end
        if (!good) begin
            m_valid = 1'b0; m_cand_ok = 1'b0;
        end else if (m_valid) begin
            if (!eq) begin m_valid = 1'b0; m_cand_ok = 1'b0; end
        end else if (m_cand_ok && eq) begin
            m_valid = 1'b1; m_w = m_cw; m_h = m_ch;
        end else begin
            m_cand_ok = 1'b1; m_cw = w; m_ch = nl;
        end
    endfunction

    task automatic set_auto(input bit v);
        if (auto_en && !v) m_fcnt = 0;
        auto_en = v;
    endtask

    // Active lines first, then a vsync pulse whose rising edge is the frame tick.
    task automatic run_frame(input int nl, input int w, input int bl, input int bw,
                             input bit rq, input logic [2:0] rp, input logic [2:0] prev_pat,
                             input logic [2:0] e_pat, input int e_w, input int e_h,
                             input bit e_v);
        for (int l = 0; l < nl; l++) begin
            de_in = 1'b1;
            repeat ((l == bl) ? bw : w) tick();
            de_in = 1'b0;
            hs_in = 1'b1;
            tick();
            hs_in = 1'b0;
            repeat (3) tick();
            if (rq && l == nl / 2) begin
                sel_if.sel_req     = 1'b1;
                sel_if.sel_pattern = rp;
            end
        end
        chk("pattern_hold", pattern, prev_pat);
        vs_in = 1'b1;
        tick();
        chk("pattern", pattern, e_pat);
        chk("width", width, e_w);
        chk("height", height, e_h);
        chk("geom_valid", geom_valid, e_v);
        chk("sel_ack", sel_if.sel_ack, rq);
        sel_if.sel_req = 1'b0;
        tick();
        if (rq) chk("sel_ack_pulse", sel_if.sel_ack, 1'b0);
        vs_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic model_frame(input int nl, input int w, input int bl, input int bw,
                               input bit rq, input logic [2:0] rp);
        logic [2:0] prev;
        prev = 3'(m_pat);
        model_ft(nl, w, bl, bw, rq, rp);
        run_frame(nl, w, bl, bw, rq, rp, prev, 3'(m_pat), m_w, m_h, m_valid);
    endtask

    int auto_exp[23] = '{0, 0, 2, 2, 2, 3, 3, 3, 4, 4, 4, 5, 5, 5, 6, 6, 6, 7, 7, 7, 0, 0, 0};

    initial begin
        logic [2:0] prev;
        int kind, nl, w, bl, bw;
        bit rq;
        logic [2:0] rp;

        // nl, w, bad_line, bad_w, auto, req, rpat, exp pattern, exp width, exp height, exp valid
        add(8, 16, -1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(8, 16, -1, 0, 0, 0, 0, 0, 16, 8, 1);
        add(8, 16, 3, 15, 0, 0, 0, 0, 16, 8, 0);
        add(8, 16, -1, 0, 0, 0, 0, 0, 16, 8, 0);
        add(8, 16, -1, 0, 0, 0, 0, 0, 16, 8, 1);
        add(8, 16, -1, 0, 0, 1, 5, 5, 16, 8, 1);
        add(8, 16, -1, 0, 1, 1, 0, 0, 16, 8, 1);
        foreach (auto_exp[i]) add(8, 16, -1, 0, 1, 0, 0, 3'(auto_exp[i]), 16, 8, 1);
        add(8, 16, -1, 0, 1, 1, 6, 6, 16, 8, 1);
        add(8, 16, -1, 0, 1, 0, 0, 6, 16, 8, 1);
        add(8, 16, -1, 0, 1, 0, 0, 6, 16, 8, 1);
        add(8, 16, -1, 0, 1, 0, 0, 7, 16, 8, 1);
        add(8, 16, -1, 0, 0, 0, 0, 7, 16, 8, 1);

        reset_n = 1'b0; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; auto_en = 1'b0;
        sel_if.sel_req = 1'b0; sel_if.sel_pattern = 3'd0;
        model_reset();
        repeat (3) tick();
        chk("rst_pattern", pattern, 3'd0);
        chk("rst_width", width, 0);
        chk("rst_height", height, 0);
        chk("rst_geom_valid", geom_valid, 1'b0);
        chk("rst_sel_ack", sel_if.sel_ack, 1'b0);
        reset_n = 1'b1;
        tick();

        prev = 3'd0;
        foreach (vecs[i]) begin
            set_auto(vecs[i].auto_on);
            model_ft(vecs[i].nl, vecs[i].w, vecs[i].bad_line, vecs[i].bad_w,
                     vecs[i].req, vecs[i].rpat);
            run_frame(vecs[i].nl, vecs[i].w, vecs[i].bad_line, vecs[i].bad_w,
                      vecs[i].req, vecs[i].rpat, prev, vecs[i].e_pat, vecs[i].e_w,
                      vecs[i].e_h, vecs[i].e_v);
            prev = vecs[i].e_pat;
        end

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) set_auto(!auto_en);
            kind = $urandom_range(0, 9);
            if (kind < 6) begin nl = 8; w = 16; bl = -1; bw = 0; end
            else if (kind < 8) begin nl = 6; w = 12; bl = -1; bw = 0; end
            else begin nl = 8; w = 16; bl = $urandom_range(1, 7); bw = $urandom_range(1, 15); end
            rq = ($urandom_range(0, 3) == 0);
            rp = 3'($urandom_range(0, 7));
            model_frame(nl, w, bl, bw, rq, rp);
        end

        // Asynchronous reset in the middle of an active line while locked.
        set_auto(1'b0);
        model_frame(8, 16, -1, 0, 1'b0, 3'd0);
        model_frame(8, 16, -1, 0, 1'b0, 3'd0);
        chk("pre_reset_lock", geom_valid, 1'b1);
        for (int l = 0; l < 2; l++) begin
            de_in = 1'b1;
            repeat (16) tick();
            de_in = 1'b0;
            repeat (4) tick();
        end
        de_in = 1'b1;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pattern", pattern, 3'd0);
        chk("mid_rst_width", width, 0);
        chk("mid_rst_height", height, 0);
        chk("mid_rst_geom_valid", geom_valid, 1'b0);
        repeat (2) tick();
        de_in = 1'b0;
        reset_n = 1'b1;
        model_reset();
        tick();
        model_frame(5, 16, -1, 0, 1'b0, 3'd0);
        model_frame(8, 16, -1, 0, 1'b0, 3'd0);
        model_frame(8, 16, -1, 0, 1'b0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
